// File: rtl/ms_port_responder_if.sv
// Port bus and transmit stream between a MaquinaSencilla core and its I/O responder.
interface ms_port_responder_if;
   logic [4:0]  dirport;
   logic [15:0] outport;
   logic        we;
   logic [15:0] inport;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output dirport, outport, we, tx_ready,
      input  inport, tx_data, tx_valid
   );

   modport slave (
      input  dirport, outport, we, tx_ready,
      output inport, tx_data, tx_valid
   );
endinterface

// File: rtl/ms_port_responder.sv
// Port-mapped I/O responder: scratch registers, transmit FIFO with stream drain,
// down-counting timer with sticky expiry, synchronized GPIO inputs and GPIO output.
module ms_port_responder #(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   ms_port_responder_if.slave  bus,
   input  logic [15:0]         gpio_in,
   output logic [15:0]         gpio_out,
   output logic                irq
);

   localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [7:0] DEPTH_C = 8'(FIFO_DEPTH);

   logic [15:0]   scratch [8];
   logic [15:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [7:0]    fifo_cnt;
   logic          overflow, expired;
   logic [15:0]   tmr_cnt, tmr_reload;
   logic          tmr_en, tmr_auto;
   logic [15:0]   sync_q [SYNC_STAGES];
   logic [15:0]   rdata;

   logic fifo_empty, fifo_full, pop, push_ok, ovf_set, tmr_zero;
   logic wr_scr, wr_fifo, wr_stat, wr_cnt, wr_rld, wr_ctl, wr_gpo;

   assign wr_scr  = bus.we && (bus.dirport[4:3] == 2'b00);
   assign wr_fifo = bus.we && (bus.dirport == 5'h08);
   assign wr_stat = bus.we && (bus.dirport == 5'h09);
   assign wr_cnt  = bus.we && (bus.dirport == 5'h0A);
   assign wr_rld  = bus.we && (bus.dirport == 5'h0B);
   assign wr_ctl  = bus.we && (bus.dirport == 5'h0C);
   assign wr_gpo  = bus.we && (bus.dirport == 5'h11);

   assign fifo_empty = (fifo_cnt == 8'd0);
   assign fifo_full  = (fifo_cnt == DEPTH_C);
   assign pop        = !fifo_empty && bus.tx_ready;
   // A pop in the same cycle frees a slot, so a push at full is still accepted.
   assign push_ok    = wr_fifo && (!fifo_full || pop);
   assign ovf_set    = wr_fifo && !push_ok;
   assign tmr_zero   = tmr_en && (tmr_cnt == 16'd0);

   assign bus.tx_valid = !fifo_empty;
   assign bus.tx_data  = fifo_empty ? 16'd0 : fifo_mem[rd_ptr];
   assign bus.inport   = rdata;
   assign irq          = overflow | expired;

   // Scratch register file and GPIO output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) scratch[i] <= '0;
         gpio_out <= '0;
      end else begin
         if (wr_scr) scratch[bus.dirport[2:0]] <= bus.outport;
         if (wr_gpo) gpio_out <= bus.outport;
      end
   end

   // FIFO storage; contents are only observable through the count, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= bus.outport;
   end

   // FIFO pointers, occupancy and sticky overflow (set beats write-1-to-clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 8'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 8'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         overflow <= ovf_set | (overflow & ~(wr_stat & bus.outport[2]));
      end
   end

   // Down-counting timer; core writes to the count win over decrement/reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_cnt    <= '0;
         tmr_reload <= '0;
         tmr_en     <= 1'b0;
         tmr_auto   <= 1'b0;
         expired    <= 1'b0;
      end else begin
         if (wr_cnt)
            tmr_cnt <= bus.outport;
         else if (tmr_zero) begin
            if (tmr_auto) tmr_cnt <= tmr_reload;
         end else if (tmr_en)
            tmr_cnt <= tmr_cnt - 16'd1;

         if (wr_rld) tmr_reload <= bus.outport;

         if (wr_ctl) begin
            tmr_en   <= bus.outport[0];
            tmr_auto <= bus.outport[1];
         end else if (tmr_zero && !tmr_auto)
            tmr_en <= 1'b0;

         expired <= tmr_zero | (expired & ~(wr_stat & bus.outport[3]));
      end
   end

   // Metastability chain for the asynchronous GPIO inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Read mux: reflects register state ahead of any write on the coming edge.
   always_comb begin
      rdata = '0;
      if (bus.dirport[4:3] == 2'b00)
         rdata = scratch[bus.dirport[2:0]];
      else begin
         case (bus.dirport)
            5'h08:   rdata = bus.tx_data;
            5'h09:   rdata = {fifo_cnt, 4'b0000, expired, overflow, fifo_full, fifo_empty};
            5'h0A:   rdata = tmr_cnt;
            5'h0B:   rdata = tmr_reload;
            5'h0C:   rdata = {14'd0, tmr_auto, tmr_en};
            5'h10:   rdata = sync_q[SYNC_STAGES-1];
            5'h11:   rdata = gpio_out;
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ms_port_responder.sv
// Directed bench for ms_port_responder: scratch, FIFO/stream, timer, GPIO, reset.
module tb_ms_port_responder;

   logic        clk;
   logic        rst_n;
   logic [15:0] gpio_in;
   logic [15:0] gpio_out;
   logic        irq;
   int          checks;
   int          failures;

   ms_port_responder_if bus ();

   ms_port_responder #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [15:0] exp);
      bus.dirport = a;
      #1;
      chk(tag, bus.inport, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [15:0] d);
      bus.dirport = a;
      bus.outport = d;
      bus.we      = 1'b1;
      tick();
      bus.we      = 1'b0;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      gpio_in     = '0;
      bus.dirport = '0;
      bus.outport = '0;
      bus.we      = 1'b0;
      bus.tx_ready = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_tx_valid", {15'd0, bus.tx_valid}, 16'h0000);
      chk("rst_tx_data", bus.tx_data, 16'h0000);
      chk("rst_irq", {15'd0, irq}, 16'h0000);
      chk("rst_gpio_out", gpio_out, 16'h0000);
      rd("rst_status", 5'h09, 16'h0001);
      rd("rst_scr0", 5'h00, 16'h0000);
      rst_n = 1'b1;
      tick();
      rd("post_rst_status", 5'h09, 16'h0001);

      // scratch: read-before-write, then write visibility
      bus.dirport = 5'h03;
      bus.outport = 16'h1234;
      bus.we      = 1'b1;
      #1;
      chk("scr3_before_edge", bus.inport, 16'h0000);
      tick();
      bus.we = 1'b0;
      rd("scr3_after", 5'h03, 16'h1234);
      rd("scr4_untouched", 5'h04, 16'h0000);
      wr(5'h07, 16'hA5A5);
      rd("scr7", 5'h07, 16'hA5A5);
      wr(5'h1F, 16'hFFFF);
      rd("unlisted_1f", 5'h1F, 16'h0000);

      // FIFO fill and overflow
      for (int i = 0; i < 8; i++) wr(5'h08, 16'h0100 + 16'(i));
      rd("status_full", 5'h09, 16'h0802);
      chk("head_first", bus.tx_data, 16'h0100);
      rd("port8_head", 5'h08, 16'h0100);
      chk("irq_before_ovf", {15'd0, irq}, 16'h0000);
      wr(5'h08, 16'h0999);
      rd("status_ovf", 5'h09, 16'h0806);
      chk("irq_ovf", {15'd0, irq}, 16'h0001);
      wr(5'h09, 16'h0004);
      rd("status_ovf_clr", 5'h09, 16'h0802);
      chk("irq_ovf_clr", {15'd0, irq}, 16'h0000);

      // simultaneous push and pop at full
      bus.tx_ready = 1'b1;
      wr(5'h08, 16'h0200);
      bus.tx_ready = 1'b0;
      rd("status_pushpop_full", 5'h09, 16'h0802);
      chk("head_after_pushpop", bus.tx_data, 16'h0101);

      // drain all eight entries
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_data", bus.tx_data, (i < 7) ? 16'h0101 + 16'(i) : 16'h0200);
         tick();
      end
      bus.tx_ready = 1'b0;
      chk("drain_valid", {15'd0, bus.tx_valid}, 16'h0000);
      rd("drain_status", 5'h09, 16'h0001);
      rd("port8_empty", 5'h08, 16'h0000);

      // stream A, B, C with stall then drain
      wr(5'h08, 16'h000A);
      wr(5'h08, 16'h000B);
      wr(5'h08, 16'h000C);
      tick();
      tick();
      chk("stall_data", bus.tx_data, 16'h000A);
      bus.tx_ready = 1'b1;
      #1;
      chk("stream_a", bus.tx_data, 16'h000A);
      tick();
      chk("stream_b", bus.tx_data, 16'h000B);
      tick();
      chk("stream_c", bus.tx_data, 16'h000C);
      tick();
      chk("stream_done", {15'd0, bus.tx_valid}, 16'h0000);
      bus.tx_ready = 1'b0;

      // timer one-shot
      wr(5'h0B, 16'h0000);
      wr(5'h0A, 16'h0003);
      wr(5'h0C, 16'h0001);
      rd("os_count0", 5'h0A, 16'h0003);
      rd("os_ctl", 5'h0C, 16'h0001);
      tick();
      tick();
      tick();
      rd("os_count_zero", 5'h0A, 16'h0000);
      rd("os_not_yet", 5'h09, 16'h0001);
      wr(5'h09, 16'h0008);
      rd("os_expired_set_wins", 5'h09, 16'h0009);
      rd("os_ctl_cleared", 5'h0C, 16'h0000);
      chk("os_irq", {15'd0, irq}, 16'h0001);
      wr(5'h09, 16'h0008);
      rd("os_expired_clr", 5'h09, 16'h0001);
      chk("os_irq_clr", {15'd0, irq}, 16'h0000);
      tick();
      rd("os_count_hold", 5'h0A, 16'h0000);

      // timer auto-reload
      wr(5'h0B, 16'h0002);
      wr(5'h0A, 16'h0002);
      wr(5'h0C, 16'h0003);
      rd("ar_ctl", 5'h0C, 16'h0003);
      tick();
      tick();
      rd("ar_cnt_e2", 5'h0A, 16'h0000);
      rd("ar_stat_e2", 5'h09, 16'h0001);
      tick();
      rd("ar_stat_e3", 5'h09, 16'h0009);
      rd("ar_cnt_e3", 5'h0A, 16'h0002);
      wr(5'h09, 16'h0008);
      rd("ar_cnt_e4", 5'h0A, 16'h0001);
      tick();
      rd("ar_stat_e5", 5'h09, 16'h0001);
      tick();
      rd("ar_stat_e6", 5'h09, 16'h0009);
      wr(5'h09, 16'h0008);
      wr(5'h0A, 16'h0010);
      rd("ar_loaded", 5'h0A, 16'h0010);
      repeat (16) tick();
      rd("ar_cnt_16", 5'h0A, 16'h0000);
      rd("ar_stat_16", 5'h09, 16'h0001);
      tick();
      rd("ar_stat_17", 5'h09, 16'h0009);
      rd("ar_cnt_17", 5'h0A, 16'h0002);
      chk("ar_irq", {15'd0, irq}, 16'h0001);
      wr(5'h0C, 16'h0000);
      wr(5'h09, 16'h0008);
      rd("ar_stopped", 5'h09, 16'h0001);
      chk("ar_irq_clr", {15'd0, irq}, 16'h0000);

      // GPIO
      gpio_in = 16'hBEEF;
      rd("gpio_0edge", 5'h10, 16'h0000);
      tick();
      rd("gpio_1edge", 5'h10, 16'h0000);
      tick();
      rd("gpio_2edge", 5'h10, 16'hBEEF);
      wr(5'h11, 16'h00FF);
      chk("gpio_out", gpio_out, 16'h00FF);
      rd("gpio_out_rd", 5'h11, 16'h00FF);

      // reset mid-operation
      wr(5'h08, 16'h0055);
      chk("pre_rst_valid", {15'd0, bus.tx_valid}, 16'h0001);
      #5;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gpio_out", gpio_out, 16'h0000);
      chk("mid_rst_valid", {15'd0, bus.tx_valid}, 16'h0000);
      chk("mid_rst_tx_data", bus.tx_data, 16'h0000);
      rd("mid_rst_scr3", 5'h03, 16'h0000);
      rd("mid_rst_gpio_in", 5'h10, 16'h0000);
      tick();
      rst_n = 1'b1;
      tick();
      rd("after_rst_status", 5'h09, 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ms_port_responder.md
# ms_port_responder

Port-mapped I/O responder for the MaquinaSencilla port bus: it decodes `dirport`, returns read data on `inport` and captures `outport` on `we`. It provides eight scratch registers, a transmit FIFO drained through a valid/ready stream, a down-counting timer with sticky expiry, synchronized GPIO inputs and a GPIO output register. It sits between the processor core and board-level I/O, with one instance per core.

## Interface
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, 2..128.
- `SYNC_STAGES`, 2: flip-flop stages on `gpio_in`; minimum 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dirport` in 5: port address from the core.
- `outport` in 16: write data from the core.
- `we` in 1: write strobe; one write per cycle while high.
- `inport` out 16: read data, combinational from `dirport`.
- `tx_data` out 16: FIFO head.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: consumer accepts the head when it is high together with `tx_valid`.
- `gpio_in` in 16: asynchronous external inputs.
- `gpio_out` out 16: output register.
- `irq` out 1: equals overflow OR expired.

## Operation
- **Port map** (unlisted addresses read 0; writes to them are ignored):
  - 0x00–0x07: scratch registers, R/W.
  - 0x08: write pushes `outport` into the FIFO. Read returns the head without popping, or 0 when empty.
  - 0x09: status. [0] empty, [1] full, [2] overflow (sticky), [3] expired (sticky), [7:4] 0, [15:8] FIFO count. A write clears each sticky bit whose `outport` bit is 1 (write-1-to-clear).
  - 0x0A: timer count. Read returns the current value; write loads it.
  - 0x0B: timer reload, R/W.
  - 0x0C: timer control. [0] enable, [1] auto-reload, other bits read 0.
  - 0x10: synchronized `gpio_in`, read-only.
  - 0x11: `gpio_out` register, R/W.
- **Reads**: `inport` reflects register state before any write on the same edge. There are no read side effects.
- **FIFO**:
  - A push is accepted when not full, or when a pop happens in the same cycle.
  - A push that is rejected drops the data and sets overflow.
  - A pop happens when `tx_valid` and `tx_ready` are both high.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Timer**: while enable=1, the count decrements by 1 per cycle. On a cycle with enable=1 and count=0:
  - expired is set;
  - if auto-reload=1, count is loaded from reload;
  - otherwise enable clears and count holds at 0.
- **Priority rules**:
  - A core write to 0x0A overrides the decrement or reload in that cycle.
  - When expiry and a write-1-to-clear of expired occur in the same cycle, the set wins.
  - When overflow and a write-1-to-clear of overflow occur in the same cycle, the set wins.
  - A write to 0x0C that sets enable takes effect from the next cycle.

## Timing
- **Reset values**:
  - All registers, FIFO pointers, count, timer count, reload, control, sticky bits, `gpio_out` and the sync chain are 0.
  - Therefore `tx_valid`=0, `tx_data`=0, `irq`=0 and `gpio_out`=0.
  - `inport` reads 0x0001 at address 0x09 and 0 at every other address.
- Reset can assert mid-operation at any cycle. It immediately empties the FIFO, stops the timer and discards all contents.
- **Write latency**: a write is visible on `inport`, `gpio_out`, `tx_valid`, `tx_data` and status from the cycle after the capturing edge.
- **Stream side**: `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0. The pop takes effect at the edge and the next head appears the following cycle.
- **`gpio_in` latency**: a change appears at 0x10 after `SYNC_STAGES` edges.
- **`irq`**: registered-signal derived, so it rises in the cycle after the setting edge and falls in the cycle after the clearing edge.
- **Timer period**: with auto-reload and reload=N, expiry occurs every N+1 cycles.

## Test plan
- **Reset and scratch**: release reset, then read 0x09 -> 0x0001. Write 0x1234 to 0x03 -> read 0x03 = 0x1234 next cycle; 0x04 stays 0.
- **FIFO fill and overflow**: with `tx_ready`=0, push 9 values (DEPTH=8) -> status 0x0802 after 8 pushes, 0x0806 after the 9th, `irq`=1. Write 0x0004 to 0x09 -> overflow clears and `irq`=0.
- **Stream drain**: push 0xA, 0xB, 0xC, then hold `tx_ready`=1 -> `tx_data` goes A, B, C on consecutive cycles, then `tx_valid`=0. Simultaneous push+pop at full -> count stays 8 and no overflow.
- **Timer one-shot**: reload=0, count=3, control=0x1 -> expired sets 4 cycles after enable and enable reads 0. Write 0x0008 to 0x09 on the expiry edge -> expired stays 1.
- **Timer auto-reload**: reload=2, control=0x3 -> expiry every 3 cycles. A write of 0x10 to 0x0A mid-count -> the next expiry comes 17 cycles later.
- **GPIO**: drive `gpio_in`=0xBEEF -> 0x10 reads 0xBEEF after 2 edges and 0 before. Write 0x00FF to 0x11 -> `gpio_out`=0x00FF next cycle. Reset mid-test -> `gpio_out`=0 immediately.
